// File: rtl/redpitaya_dac_pkg.sv
// Shared types and code conversion helpers for the Red Pitaya DAC DDR transmitter.
// Optional feature macro used by the top: REDPITAYA_DAC_UNDERFLOW_CNT_EN.
package redpitaya_dac_pkg;

   typedef enum logic [1:0] {StMute, StWarmup, StRun} dac_state_e;

   // Mid-scale (zero) code in offset binary for a dac_w-bit converter.
   function automatic logic [31:0] mid_scale(input int unsigned dac_w);
      return 32'h1 << (dac_w - 1);
   endfunction

   // Clamp a signed sample to the dac_w-bit two's complement range, then flip the MSB.
   function automatic logic [31:0] sat_offset(input logic signed [31:0] x,
                                              input int unsigned dac_w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      logic signed [31:0] y;
      hi = signed'(mid_scale(dac_w) - 32'd1);
      lo = -signed'(mid_scale(dac_w));
      if (x > hi) begin
         y = hi;
      end else if (x < lo) begin
         y = lo;
      end else begin
         y = x;
      end
      return (32'(y) ^ mid_scale(dac_w)) & ((mid_scale(dac_w) << 1) - 32'd1);
   endfunction

endpackage

// File: rtl/redpitaya_dac_fifo.sv
// Synchronous sample-pair FIFO with flush and a registered read port.
module redpitaya_dac_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             wr_en_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [Width-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW:0]   wr_ptr_q;
   logic [AddrW:0]   rd_ptr_q;
   logic [Width-1:0] rd_data_q;
   logic             do_wr;
   logic             do_rd;

   // Extra pointer bit separates full from empty when the address bits match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   assign do_wr   = wr_en_i && !full_o;
   assign do_rd   = rd_en_i && !empty_o;
   assign rd_data_o = rd_data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_data_q <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_rd) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_data_q <= mem_q[rd_ptr_q[AddrW-1:0]];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
      end
   end

endmodule

// File: rtl/redpitaya_dac_ddr_tx.sv
// Two-channel DAC feeder: FIFO, mute/warm-up/run sequencing and offset-binary conversion.
// Define REDPITAYA_DAC_UNDERFLOW_CNT_EN to add the saturating underflow_cnt_o counter.
module redpitaya_dac_ddr_tx
   import redpitaya_dac_pkg::*;
#(
   parameter int unsigned IN_WIDTH      = 16,
   parameter int unsigned DAC_WIDTH     = 14,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned WARMUP_CYCLES = 256
) (
   input  logic                 dac_clk_i,
   input  logic                 dac_rst_i,
   input  logic                 dac_locked_i,
   input  logic                 enable_i,
   input  logic [IN_WIDTH-1:0]  data_a_i,
   input  logic [IN_WIDTH-1:0]  data_b_i,
   input  logic                 data_en_i,
   output logic                 data_rdy_o,
   output logic [DAC_WIDTH-1:0] dac_dat_rise_o,
   output logic [DAC_WIDTH-1:0] dac_dat_fall_o,
   output logic                 dac_sel_rise_o,
   output logic                 dac_sel_fall_o,
   output logic                 dac_wrt_rise_o,
   output logic                 dac_wrt_fall_o,
   output logic                 active_o,
   output logic                 underflow_o
`ifdef REDPITAYA_DAC_UNDERFLOW_CNT_EN
   ,
   output logic [31:0]          underflow_cnt_o
`endif
);

   localparam logic [DAC_WIDTH-1:0] MidScale   = DAC_WIDTH'(mid_scale(DAC_WIDTH));
   localparam logic [15:0]          WarmupLast = 16'(WARMUP_CYCLES - 1);

   dac_state_e              state_q, state_d;
   logic [15:0]             warm_cnt_q, warm_cnt_d;
   logic                    run_ok;
   logic                    fifo_full, fifo_empty, fifo_wr, fifo_rd;
   logic [2*IN_WIDTH-1:0]   fifo_rd_data;
   logic                    pop_valid_q;
   logic signed [31:0]      a_ext, b_ext;
   logic [DAC_WIDTH-1:0]    a_code, b_code;
   logic [DAC_WIDTH-1:0]    dat_rise_q, dat_fall_q;

   assign run_ok     = dac_locked_i && enable_i;
   assign data_rdy_o = ((state_q == StWarmup) || (state_q == StRun)) && !fifo_full;
   assign fifo_wr    = data_en_i && data_rdy_o;
   assign fifo_rd    = (state_q == StRun) && !fifo_empty;
   assign active_o   = (state_q == StRun);
   assign underflow_o = (state_q == StRun) && fifo_empty;

   redpitaya_dac_fifo #(
      .Width (2 * IN_WIDTH),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (dac_clk_i),
      .rst_i     (dac_rst_i),
      .flush_i   (!run_ok),
      .wr_en_i   (fifo_wr),
      .wr_data_i ({data_a_i, data_b_i}),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // Losing lock or enable overrides every other transition.
   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      if (!run_ok) begin
         state_d = StMute;
      end else begin
         unique case (state_q)
            StMute: begin
               state_d    = StWarmup;
               warm_cnt_d = '0;
            end
            StWarmup: begin
               if (warm_cnt_q == WarmupLast) begin
                  if (!fifo_empty) begin
                     state_d = StRun;
                  end
               end else begin
                  warm_cnt_d = warm_cnt_q + 16'd1;
               end
            end
            StRun: begin
               state_d = StRun;
            end
            default: begin
               state_d = StMute;
            end
         endcase
      end
   end

   assign a_ext  = {{(32 - IN_WIDTH){fifo_rd_data[2*IN_WIDTH-1]}},
                    fifo_rd_data[2*IN_WIDTH-1:IN_WIDTH]};
   assign b_ext  = {{(32 - IN_WIDTH){fifo_rd_data[IN_WIDTH-1]}}, fifo_rd_data[IN_WIDTH-1:0]};
   assign a_code = DAC_WIDTH'(sat_offset(a_ext, DAC_WIDTH));
   assign b_code = DAC_WIDTH'(sat_offset(b_ext, DAC_WIDTH));

   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         state_q     <= StMute;
         warm_cnt_q  <= '0;
         pop_valid_q <= 1'b0;
         dat_rise_q  <= MidScale;
         dat_fall_q  <= MidScale;
      end else begin
         state_q     <= state_d;
         warm_cnt_q  <= warm_cnt_d;
         pop_valid_q <= fifo_rd && run_ok;
         // Without a fresh pop the last code is held; outside RUN the DAC sits at mid-scale.
         if (state_d != StRun) begin
            dat_rise_q <= MidScale;
            dat_fall_q <= MidScale;
         end else if (pop_valid_q) begin
            dat_rise_q <= a_code;
            dat_fall_q <= b_code;
         end
      end
   end

   assign dac_dat_rise_o = dat_rise_q;
   assign dac_dat_fall_o = dat_fall_q;
   assign dac_wrt_rise_o = 1'b0;
   assign dac_wrt_fall_o = (state_q != StMute);
   assign dac_sel_rise_o = (state_q != StMute);
   assign dac_sel_fall_o = 1'b0;

`ifdef REDPITAYA_DAC_UNDERFLOW_CNT_EN
   logic [31:0] ufl_cnt_q;

   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         ufl_cnt_q <= '0;
      end else if (underflow_o && (ufl_cnt_q != 32'hFFFF_FFFF)) begin
         ufl_cnt_q <= ufl_cnt_q + 32'd1;
      end
   end

   assign underflow_cnt_o = ufl_cnt_q;
`endif

endmodule

// File: tb/tb_redpitaya_dac_ddr_tx.sv
// Directed bench for redpitaya_dac_ddr_tx (default parameters, optional counter via macro).
module tb_redpitaya_dac_ddr_tx;

   logic        clk = 1'b0;
   logic        rst, locked, enable, den, rdy;
   logic [15:0] a, b;
   logic [13:0] dat_rise, dat_fall;
   logic        sel_rise, sel_fall, wrt_rise, wrt_fall, active, underflow;
   int          n_cmp = 0;
   int          n_err = 0;
`ifdef REDPITAYA_DAC_UNDERFLOW_CNT_EN
   logic [31:0] ufl_cnt;
`endif

   always #5 clk = ~clk;

   redpitaya_dac_ddr_tx dut (
      .dac_clk_i      (clk),
      .dac_rst_i      (rst),
      .dac_locked_i   (locked),
      .enable_i       (enable),
      .data_a_i       (a),
      .data_b_i       (b),
      .data_en_i      (den),
      .data_rdy_o     (rdy),
      .dac_dat_rise_o (dat_rise),
      .dac_dat_fall_o (dat_fall),
      .dac_sel_rise_o (sel_rise),
      .dac_sel_fall_o (sel_fall),
      .dac_wrt_rise_o (wrt_rise),
      .dac_wrt_fall_o (wrt_fall),
      .active_o       (active),
      .underflow_o    (underflow)
`ifdef REDPITAYA_DAC_UNDERFLOW_CNT_EN
      ,
      .underflow_cnt_o (ufl_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dat(input string tag, input logic [13:0] er, input logic [13:0] ef);
      chk({tag, "_rise"}, 32'(dat_rise), 32'(er));
      chk({tag, "_fall"}, 32'(dat_fall), 32'(ef));
   endtask

   // Control nibble order: {wrt_rise, wrt_fall, sel_rise, sel_fall}.
   task automatic chk_ctrl(input string tag, input logic [3:0] exp);
      chk(tag, 32'({wrt_rise, wrt_fall, sel_rise, sel_fall}), 32'(exp));
   endtask

   initial begin
      rst = 1'b1; locked = 1'b1; enable = 1'b1; den = 1'b0; a = '0; b = '0;
      step();
      step();
      chk_dat("rst_dat", 14'h2000, 14'h2000);
      chk_ctrl("rst_ctrl", 4'b0000);
      chk("rst_rdy", 32'(rdy), 0);
      chk("rst_active", 32'(active), 0);
      chk("rst_underflow", 32'(underflow), 0);
`ifdef REDPITAYA_DAC_UNDERFLOW_CNT_EN
      chk("rst_ufl_cnt", ufl_cnt, 0);
`endif

      // Warm-up with no data: idle at mid-scale for 300 cycles.
      rst = 1'b0;
      step();
      chk("warm_rdy", 32'(rdy), 1);
      chk_ctrl("warm_ctrl", 4'b0110);
      for (int i = 1; i < 300; i++) begin
         step();
         chk("warm_active", 32'(active), 0);
         chk("warm_dat", 32'(dat_rise), 32'h2000);
      end

      a = 16'h7FFF; b = 16'h8000; den = 1'b1;
      step();
      den = 1'b0;
      chk("first_wr_active", 32'(active), 0);
      step();
      chk("run_active", 32'(active), 1);
      chk("run_no_underflow", 32'(underflow), 0);
      chk_dat("run_entry_dat", 14'h2000, 14'h2000);
      step();
      chk("run_underflow", 32'(underflow), 1);
      chk_dat("pop_dat", 14'h2000, 14'h2000);
      step();
      chk_dat("sat_max_min", 14'h3FFF, 14'h0000);
      chk_ctrl("run_ctrl", 4'b0110);

      // Two-edge latency in RUN.
      a = 16'h0000; b = 16'h7FFF; den = 1'b1;
      step();
      den = 1'b0;
      chk("lat_t_underflow", 32'(underflow), 0);
      chk_dat("lat_t", 14'h3FFF, 14'h0000);
      step();
      chk_dat("lat_t1", 14'h3FFF, 14'h0000);
      chk("lat_t1_underflow", 32'(underflow), 1);
      step();
      chk_dat("lat_t2", 14'h2000, 14'h3FFF);

      // Saturation boundaries, back to back.
      a = 16'hE001; b = 16'h2000; den = 1'b1;
      step();
      a = 16'hDFFF; b = 16'h1FFE;
      step();
      den = 1'b0;
      step();
      chk_dat("bound_a", 14'h0001, 14'h3FFF);
      step();
      chk_dat("bound_b", 14'h0000, 14'h3FFE);

      // Reset while a pair is in flight.
      a = 16'h1234; b = 16'h4321; den = 1'b1;
      step();
      den = 1'b0; rst = 1'b1;
      step();
      chk_dat("midrun_rst_dat", 14'h2000, 14'h2000);
      chk("midrun_rst_active", 32'(active), 0);
      chk("midrun_rst_rdy", 32'(rdy), 0);
      chk_ctrl("midrun_rst_ctrl", 4'b0000);
      chk("midrun_rst_underflow", 32'(underflow), 0);
      rst = 1'b0;
      step();
      chk_dat("post_rst_dat", 14'h2000, 14'h2000);
      chk("post_rst_rdy", 32'(rdy), 1);
`ifdef REDPITAYA_DAC_UNDERFLOW_CNT_EN
      chk("post_rst_ufl_cnt", ufl_cnt, 0);
`endif

      // Overfill during warm-up: only the first four pairs are kept.
      for (int k = 1; k <= 8; k++) begin
         a = 16'(k * 256); b = 16'(-(k * 256)); den = 1'b1;
         step();
         chk("fill_rdy", 32'(rdy), (k < 4) ? 1 : 0);
      end
      den = 1'b0;
      repeat (247) step();
      chk("fill_active_pre", 32'(active), 0);
      step();
      chk("fill_active", 32'(active), 1);
      chk("fill_no_underflow", 32'(underflow), 0);
      step();
      chk_dat("fill_pop_dat", 14'h2000, 14'h2000);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk_dat("fill_seq", 14'(14'h2000 + k * 256), 14'(14'h2000 - k * 256));
         chk("fill_seq_underflow", 32'(underflow), (k >= 3) ? 1 : 0);
      end

      // Starved RUN holds the last code.
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_underflow", 32'(underflow), 1);
         chk_dat("hold_dat", 14'h2400, 14'h1C00);
         chk("hold_active", 32'(active), 1);
      end
`ifdef REDPITAYA_DAC_UNDERFLOW_CNT_EN
      chk("ufl_cnt_5", ufl_cnt, 5);
`endif

      // Enable drop mutes on the next edge.
      enable = 1'b0;
      step();
      chk("dis_active", 32'(active), 0);
      chk_ctrl("dis_ctrl", 4'b0000);
      chk_dat("dis_dat", 14'h2000, 14'h2000);
      chk("dis_rdy", 32'(rdy), 0);
      chk("dis_underflow", 32'(underflow), 0);

      // Lock drop with three pairs queued.
      enable = 1'b1;
      step();
      for (int k = 5; k <= 8; k++) begin
         a = 16'(k * 256); b = 16'(-(k * 256)); den = 1'b1;
         step();
      end
      den = 1'b0;
      repeat (252) step();
      chk("q3_active", 32'(active), 1);
      step();
      chk_dat("q3_pop_dat", 14'h2000, 14'h2000);
      locked = 1'b0;
      step();
      chk_dat("unlock_dat", 14'h2000, 14'h2000);
      chk_ctrl("unlock_ctrl", 4'b0000);
      chk("unlock_active", 32'(active), 0);
      chk("unlock_rdy", 32'(rdy), 0);
      chk("unlock_underflow", 32'(underflow), 0);

      // Re-lock: FIFO starts empty and warm-up runs its full length again.
      locked = 1'b1;
      step();
      chk("relock_rdy", 32'(rdy), 1);
      chk("relock_active", 32'(active), 0);
      for (int k = 1; k <= 4; k++) begin
         a = 16'(k * 256); b = 16'(-(k * 256)); den = 1'b1;
         step();
         chk("relock_fill_rdy", 32'(rdy), (k < 4) ? 1 : 0);
      end
      den = 1'b0;
      repeat (251) step();
      chk("relock_active_pre", 32'(active), 0);
      chk_dat("relock_warm_dat", 14'h2000, 14'h2000);
      step();
      chk("relock_active_run", 32'(active), 1);
      step();
      step();
      chk_dat("relock_first", 14'h2100, 14'h1F00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/redpitaya_dac_ddr_tx.md
REDPITAYA_DAC_DDR_TX -- requirements
Module: redpitaya_dac_ddr_tx

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, signed input sample width.
REQ-002 SHALL have parameter DAC_WIDTH, default 14, DAC code width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, sample-pair FIFO depth, power of two.
REQ-004 SHALL have parameter WARMUP_CYCLES, default 256, cycles held mid-scale after lock, 1..65535.
REQ-005 SHALL have one clock and synchronous active-high reset: dac_clk_i in 1 DAC clock, all logic on rising edge; dac_rst_i in 1 sync reset, active high.
REQ-006 SHALL have dac_locked_i in 1 PLL lock status; enable_i in 1 output enable.
REQ-007 SHALL have data_a_i in IN_WIDTH ch A sample; data_b_i in IN_WIDTH ch B sample; data_en_i in 1 pair valid; data_rdy_o out 1 FIFO can accept.
REQ-008 SHALL have dac_dat_rise_o out DAC_WIDTH ch A code; dac_dat_fall_o out DAC_WIDTH ch B code; both feed an external ODDR.
REQ-009 SHALL have dac_sel_rise_o, dac_sel_fall_o, dac_wrt_rise_o, dac_wrt_fall_o out 1 each, ODDR control halves.
REQ-010 SHALL have active_o out 1 state is RUN; underflow_o out 1 one-cycle underflow pulse.

Function
REQ-011 SHALL implement states MUTE, WARMUP, RUN.
REQ-012 MUTE->WARMUP when dac_locked_i=1 and enable_i=1; warmup counter cleared on entry.
REQ-013 WARMUP->RUN when counter reaches WARMUP_CYCLES-1 and FIFO non-empty; else stay in WARMUP, counter saturating.
REQ-014 Any state->MUTE in the next cycle when dac_locked_i=0 or enable_i=0; FIFO flushed on that edge; this condition wins over all transitions.
REQ-015 data_rdy_o=1 only in WARMUP or RUN and FIFO not full; write occurs when data_en_i=1 and data_rdy_o=1; data_en_i with data_rdy_o=0 is dropped, no error.
REQ-016 In RUN, one pair popped per cycle when FIFO non-empty; simultaneous write and pop SHALL keep occupancy unchanged.
REQ-017 Conversion: saturate signed input to [-2^(DAC_WIDTH-1), 2^(DAC_WIDTH-1)-1], then invert MSB (offset binary); 16-bit defaults: 0x7FFF->0x3FFF, 0x8000->0x0000, 0x0000->0x2000.
REQ-018 Latency: a pair written at edge t into an empty FIFO in RUN appears on dac_dat_*_o after edge t+2 (pop register, convert register).
REQ-019 RUN with FIFO empty: outputs hold last code; underflow_o=1 for that cycle; state stays RUN.
REQ-020 MUTE and WARMUP: both data outputs = mid-scale 2^(DAC_WIDTH-1) (0x2000).
REQ-021 WARMUP and RUN: dac_wrt_rise_o=0, dac_wrt_fall_o=1, dac_sel_rise_o=1, dac_sel_fall_o=0; MUTE: all four 0.

Reset
REQ-022 dac_rst_i=1 at an edge: state MUTE, FIFO empty, counters 0, data outputs mid-scale, control outputs, data_rdy_o, active_o, underflow_o all 0.
REQ-023 Reset mid-RUN SHALL discard FIFO contents; first post-reset output is mid-scale.

Configuration
REQ-024 With macro REDPITAYA_DAC_UNDERFLOW_CNT_EN defined: port underflow_cnt_o out 32 counts underflow cycles, saturates at 0xFFFFFFFF, cleared by reset only.
REQ-025 Without it: port absent, no counter logic; underflow_o unchanged.

Structure
REQ-026 Package redpitaya_dac_pkg SHALL hold state enum, mid-scale constant, and saturate-and-offset function.
REQ-027 FIFO SHALL be sub-module redpitaya_dac_fifo (sync, flush input, full/empty flags, registered read).

Verification
REQ-028 Reset, locked=1, enable=1, no data for 300 cycles -> outputs 0x2000, active_o=0 throughout; after data arrives, active_o=1 on the cycle after edge 256+.
REQ-029 In RUN, write A=0x7FFF/B=0x8000 at edge t -> dac_dat_rise_o=0x3FFF, dac_dat_fall_o=0x0000 after edge t+2.
REQ-030 Continuous data_en_i with FIFO full -> data_rdy_o=0, no overwrite, output sequence gapless and in order.
REQ-031 Stop input in RUN -> last code held, underflow_o high each empty cycle; with macro, underflow_cnt_o=5 after 5 empty cycles.
REQ-032 Drop dac_locked_i mid-RUN with 3 entries queued -> MUTE next cycle, outputs 0x2000, control 0, FIFO empty; re-lock restarts full WARMUP.
